// File: rtl/ball_motion.sv
// Ball position, wall/paddle reflection and hit/miss scoring for a one-player field.
// Optional BALL_SPEEDUP_EN: per-rally speed rises every 4th paddle hit, capped at 8.
module ball_motion #(
  parameter int HS          = 640,
  parameter int VS          = 480,
  parameter int BALL        = 10,
  parameter int PADDLE_X    = 20,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_H    = 120,
  parameter int BALL_SPEED  = 4,
  parameter int SERVE_TICKS = 60,
  parameter int MISS_TICKS  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] P1_paddle_y_location,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic [7:0] hit_count,
  output logic [7:0] miss_count
);

  typedef enum logic [1:0] {SERVE, PLAY, MISS} state_e;

  localparam logic [9:0]  X0     = 10'((HS - BALL) / 2);
  localparam logic [9:0]  Y0     = 10'((VS - BALL) / 2);
  localparam logic [10:0] PXW    = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] BL     = 11'(BALL);
  localparam logic [10:0] HS11   = 11'(HS);
  localparam logic [10:0] VS11   = 11'(VS);
  localparam logic [7:0]  S_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [7:0]  M_LAST = 8'(MISS_TICKS - 1);

  state_e     state_q;
  logic [9:0] x_q, y_q;
  logic       dx_q, dy_q, sdy_q, act_q;
  logic [7:0] hit_q, miss_q, cnt_q;

  logic [10:0] x11, y11, p11, step;
  logic [9:0]  nx, ny;
  logic        ndx, ndy, hit, miss;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] spd_q;
  logic [1:0] rh_q;
  assign step = {7'd0, spd_q};
`else
  assign step = 11'(BALL_SPEED);
`endif

  // Both axes evaluated from the current registers; dx=1 right, dy=1 down.
  always_comb begin
    x11  = {1'b0, x_q};
    y11  = {1'b0, y_q};
    p11  = {1'b0, P1_paddle_y_location};
    nx   = x_q;
    ny   = y_q;
    ndx  = dx_q;
    ndy  = dy_q;
    hit  = 1'b0;
    miss = 1'b0;
    if (dy_q) begin
      if (y11 + BL + step >= VS11) begin
        ny  = 10'(VS - BALL);
        ndy = 1'b0;
      end else begin
        ny = 10'(y11 + step);
      end
    end else if (y11 <= step) begin
      ny  = '0;
      ndy = 1'b1;
    end else begin
      ny = 10'(y11 - step);
    end
    if (dx_q) begin
      if (x11 + BL + step >= HS11) begin
        nx  = 10'(HS - BALL);
        ndx = 1'b0;
      end else begin
        nx = 10'(x11 + step);
      end
    end else if (x11 >= PXW && x11 - step < PXW &&
                 y11 + BL > p11 && y11 < p11 + PH) begin
      hit = 1'b1;
      nx  = 10'(PXW);
      ndx = 1'b1;
    end else if (x11 < step) begin
      miss = 1'b1;
    end else begin
      nx = 10'(x11 - step);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SERVE;
      x_q     <= X0;
      y_q     <= Y0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sdy_q   <= 1'b1;
      act_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
`ifdef BALL_SPEEDUP_EN
      spd_q   <= 4'(BALL_SPEED);
      rh_q    <= '0;
`endif
    end else if (frame_tick) begin
      case (state_q)
        SERVE: begin
          if (cnt_q == S_LAST) begin
            cnt_q   <= '0;
            state_q <= PLAY;
            act_q   <= 1'b1;
            dx_q    <= 1'b1;
            dy_q    <= sdy_q;
            sdy_q   <= ~sdy_q;
`ifdef BALL_SPEEDUP_EN
            spd_q   <= 4'(BALL_SPEED);
            rh_q    <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PLAY: begin
          if (miss) begin
            state_q <= MISS;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            miss_q  <= miss_q + {7'd0, miss_q != 8'hFF};
          end else begin
            x_q  <= nx;
            y_q  <= ny;
            dx_q <= ndx;
            dy_q <= ndy;
            if (hit) begin
              hit_q <= hit_q + {7'd0, hit_q != 8'hFF};
`ifdef BALL_SPEEDUP_EN
              rh_q <= rh_q + 2'd1;
              if (rh_q == 2'd3 && spd_q < 4'd8)
                spd_q <= spd_q + 4'd1;
`endif
            end
          end
        end
        MISS: begin
          if (cnt_q == M_LAST) begin
            cnt_q   <= '0;
            x_q     <= X0;
            y_q     <= Y0;
            state_q <= SERVE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign ball_active = act_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: hand-derived trajectory vectors, async reset,
// and random ticks/paddle checked against a signed-velocity reference model.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] pad;
  logic [9:0] bx, by;
  logic       act;
  logic [7:0] hc, mc;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .P1_paddle_y_location(pad),
    .ball_x(bx),
    .ball_y(by),
    .ball_active(act),
    .hit_count(hc),
    .miss_count(mc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm,
                       input int ex, input int ey, input int ea,
                       input int eh, input int em);
    total++;
    if (int'(bx) != ex || int'(by) != ey || int'(act) != ea ||
        int'(hc) != eh || int'(mc) != em) begin
      bad++;
      if (bad < 30)
        $display("FAIL %s: got x=%0d y=%0d act=%0d hit=%0d miss=%0d want x=%0d y=%0d act=%0d hit=%0d miss=%0d",
                 nm, bx, by, act, hc, mc, ex, ey, ea, eh, em);
    end
  endtask

  // Reference model: st 0=serve 1=play 2=miss; velocity signs vx/vy.
  int m_st, mx, my, mvx, mvy, msdy, mact, mhit, mmiss, mcnt, mspd, mrh;

  task automatic model_reset();
    m_st = 0; mx = 315; my = 235; mvx = 1; mvy = 1; msdy = 1;
    mact = 0; mhit = 0; mmiss = 0; mcnt = 0; mspd = 4; mrh = 0;
  endtask

  task automatic model_tick(input int p);
    int nx, ny, nvx, nvy;
    bit h, ms;
    nx = mx; ny = my; nvx = mvx; nvy = mvy; h = 0; ms = 0;
    case (m_st)
      0: begin
        mcnt++;
        if (mcnt == 60) begin
          mcnt = 0; m_st = 1; mact = 1; mvx = 1;
          mvy = msdy; msdy = -msdy; mspd = 4; mrh = 0;
        end
      end
      1: begin
        if (mvy > 0) begin
          if (my + 10 + mspd >= 480) begin ny = 470; nvy = -1; end
          else ny = my + mspd;
        end else if (my <= mspd) begin ny = 0; nvy = 1; end
        else ny = my - mspd;
        if (mvx > 0) begin
          if (mx + 10 + mspd >= 640) begin nx = 630; nvx = -1; end
          else nx = mx + mspd;
        end else if (mx >= 30 && mx - mspd < 30 &&
                     my + 10 > p && my < p + 120) begin
          h = 1; nx = 30; nvx = 1;
        end else if (mx < mspd) ms = 1;
        else nx = mx - mspd;
        if (ms) begin
          m_st = 2; mact = 0; mcnt = 0;
          if (mmiss < 255) mmiss++;
        end else begin
          mx = nx; my = ny; mvx = nvx; mvy = nvy;
          if (h) begin
            if (mhit < 255) mhit++;
`ifdef BALL_SPEEDUP_EN
            mrh++;
            if (mrh == 4) begin
              mrh = 0;
              if (mspd < 8) mspd++;
            end
`endif
          end
        end
      end
      default: begin
        mcnt++;
        if (mcnt == 30) begin
          mcnt = 0; m_st = 0; mx = 315; my = 235;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit rst;
    int ticks;
    int pad;
    int ex, ey, ea, eh, em;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int p;
    bit ft;
    vecs = '{
      '{1,   0, 300, 315, 235, 0, 0, 0},
      '{0,  59, 300, 315, 235, 0, 0, 0},
      '{0,   1, 300, 315, 235, 1, 0, 0},
      '{0,   1, 300, 319, 239, 1, 0, 0},
      '{0,  57, 300, 547, 467, 1, 0, 0},
      '{0,   1, 300, 551, 470, 1, 0, 0},
      '{0,  20, 300, 630, 390, 1, 0, 0},
      '{0,   1, 300, 626, 386, 1, 0, 0},
      '{0, 149, 300,  30, 208, 1, 0, 0},
      '{0,   7, 300,   2, 236, 1, 0, 0},
      '{0,   1, 300,   2, 236, 0, 0, 1},
      '{0,  29, 300,   2, 236, 0, 0, 1},
      '{0,   1, 300, 315, 235, 0, 0, 1},
      '{0,  60, 300, 315, 235, 1, 0, 1},
      '{0,   1, 300, 319, 231, 1, 0, 1},
      '{1,   0, 180, 315, 235, 0, 0, 0},
      '{0, 289, 180,  30, 208, 1, 0, 0},
      '{0,   1, 180,  30, 212, 1, 1, 0},
      '{0,   1, 180,  34, 216, 1, 1, 0}
    };
    reset = 1'b0;
    frame_tick = 1'b0;
    pad = '0;
    #12;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      repeat (vecs[i].ticks) begin
        @(negedge clk);
        frame_tick = 1'b1;
        pad = 10'(vecs[i].pad);
        @(negedge clk);
        frame_tick = 1'b0;
      end
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
            vecs[i].ea, vecs[i].eh, vecs[i].em);
    end

    // Reset between clock edges must take effect without a clk edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_rst", 315, 235, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 315, 235, 0, 0, 0);

    model_reset();
    do_reset();
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      ft = ($urandom_range(0, 3) != 0);
      if (m_st == 1 && mvx < 0 && mx < 120 && $urandom_range(0, 9) < 8) begin
        p = my - int'($urandom_range(0, 115));
        if (p < 0) p = 0;
      end else begin
        p = int'($urandom_range(0, 1023));
      end
      frame_tick = ft;
      pad = 10'(p);
      if (ft) model_tick(p);
      @(posedge clk);
      #1 check("rand", mx, my, mact, mhit, mmiss);
    end
    @(negedge clk);
    frame_tick = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
